// File: rtl/title_screen_sequencer.sv
// Title / win / gameplay screen sequencer.
// Decides which full-screen image the title colorizer shows and gates the
// game logic. The state machine reacts to events immediately, but the
// screen select presented downstream only changes on a frame boundary, so
// an image never switches mid-frame.
module title_screen_sequencer #(
   parameter int unsigned WIN_FRAMES     = 300,
   parameter int unsigned MIN_WIN_FRAMES = 60,
   parameter int unsigned BLINK_FRAMES   = 30
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_btn,
   input  logic       p1_win,
   input  logic       p2_win,
   output logic [1:0] screen_sel,
   output logic       game_enable,
   output logic       game_restart,
   output logic       blink_on
);

   // State encoding doubles as the screen code, so screen_sel can latch
   // the state register directly.
   typedef enum logic [1:0] {
      ST_TITLE = 2'b00,
      ST_WIN1  = 2'b01,
      ST_WIN2  = 2'b10,
      ST_PLAY  = 2'b11
   } state_t;

   localparam logic [15:0] WIN_LIMIT  = 16'(WIN_FRAMES);
   localparam logic [15:0] MIN_LIMIT  = 16'(MIN_WIN_FRAMES);
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

   state_t      state_reg;
   logic [15:0] frame_cnt_reg;
   logic [7:0]  blink_cnt_reg;
   logic        start_q_reg;
   logic        start_rise;

   // start_q_reg resets high so a button held through reset is not
   // mistaken for a fresh press.
   assign start_rise = start_btn & ~start_q_reg;

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_TITLE;
         frame_cnt_reg <= 16'd0;
         blink_cnt_reg <= 8'd0;
         start_q_reg   <= 1'b1;
         screen_sel    <= 2'b00;
         game_enable   <= 1'b0;
         game_restart  <= 1'b0;
         blink_on      <= 1'b0;
      end else begin
         start_q_reg  <= start_btn;
         game_restart <= 1'b0;

         // Frame-aligned screen select uses the pre-update state.
         if (frame_tick) begin
            screen_sel <= state_reg;
         end

         case (state_reg)
            ST_TITLE: begin
               if (start_rise) begin
                  state_reg     <= ST_PLAY;
                  game_enable   <= 1'b1;
                  game_restart  <= 1'b1;
                  blink_on      <= 1'b0;
                  blink_cnt_reg <= 8'd0;
               end else if (frame_tick) begin
                  if (blink_cnt_reg == BLINK_LAST) begin
                     blink_cnt_reg <= 8'd0;
                     blink_on      <= ~blink_on;
                  end else begin
                     blink_cnt_reg <= blink_cnt_reg + 8'd1;
                  end
               end
            end

            ST_PLAY: begin
               // p1 has priority when both wins land in the same cycle.
               if (p1_win) begin
                  state_reg     <= ST_WIN1;
                  game_enable   <= 1'b0;
                  frame_cnt_reg <= 16'd0;
               end else if (p2_win) begin
                  state_reg     <= ST_WIN2;
                  game_enable   <= 1'b0;
                  frame_cnt_reg <= 16'd0;
               end
            end

            ST_WIN1, ST_WIN2: begin
               if ((frame_cnt_reg >= WIN_LIMIT) ||
                   (start_rise && (frame_cnt_reg >= MIN_LIMIT))) begin
                  state_reg     <= ST_TITLE;
                  blink_cnt_reg <= 8'd0;
                  blink_on      <= 1'b0;
               end else if (frame_tick && (frame_cnt_reg != 16'hFFFF)) begin
                  frame_cnt_reg <= frame_cnt_reg + 16'd1;
               end
            end

            default: begin
               state_reg   <= ST_TITLE;
               game_enable <= 1'b0;
               blink_on    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_title_screen_sequencer.sv
// Bench for title_screen_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a screen-level reference model.
module tb_title_screen_sequencer;

   localparam int WIN_F   = 4;
   localparam int MIN_F   = 2;
   localparam int BLINK_F = 3;

   // Screen codes as seen by the colorizer.
   localparam int SCR_TITLE = 0;
   localparam int SCR_P1    = 1;
   localparam int SCR_P2    = 2;
   localparam int SCR_GAME  = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       start_btn = 1'b1;
   logic       p1_win = 1'b0;
   logic       p2_win = 1'b0;
   logic [1:0] screen_sel;
   logic       game_enable;
   logic       game_restart;
   logic       blink_on;

   int checks = 0;
   int failures = 0;

   // Reference model: which screen the game is on, and what has been shown.
   int m_screen;       // screen the game is logically on
   int m_shown;        // screen presented to the colorizer
   bit m_last_btn;
   int m_win_frames;   // frames spent on the current win screen
   int m_title_ticks;  // ticks since last blink toggle
   bit m_blink;
   bit m_restart;

   title_screen_sequencer #(
      .WIN_FRAMES    (WIN_F),
      .MIN_WIN_FRAMES(MIN_F),
      .BLINK_FRAMES  (BLINK_F)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .start_btn   (start_btn),
      .p1_win      (p1_win),
      .p2_win      (p2_win),
      .screen_sel  (screen_sel),
      .game_enable (game_enable),
      .game_restart(game_restart),
      .blink_on    (blink_on)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_screen      = SCR_TITLE;
      m_shown       = SCR_TITLE;
      m_last_btn    = 1'b1;
      m_win_frames  = 0;
      m_title_ticks = 0;
      m_blink       = 1'b0;
      m_restart     = 1'b0;
   endtask

   // One clock of game rules, applied to the inputs present at the edge.
   task automatic model_step(input bit t, input bit b, input bit w1, input bit w2);
      bit pressed;
      pressed    = b && !m_last_btn;
      m_last_btn = b;
      m_restart  = 1'b0;
      if (t) m_shown = m_screen;
      if (m_screen == SCR_TITLE) begin
         if (pressed) begin
            m_screen  = SCR_GAME;
            m_restart = 1'b1;
            m_blink   = 1'b0;
         end else if (t) begin
            m_title_ticks++;
            if (m_title_ticks == BLINK_F) begin
               m_title_ticks = 0;
               m_blink = !m_blink;
            end
         end
      end else if (m_screen == SCR_GAME) begin
         if (w1 || w2) begin
            m_screen     = w1 ? SCR_P1 : SCR_P2;
            m_win_frames = 0;
         end
      end else begin
         if (m_win_frames >= WIN_F || (pressed && m_win_frames >= MIN_F)) begin
            m_screen      = SCR_TITLE;
            m_title_ticks = 0;
            m_blink       = 1'b0;
         end else if (t && m_win_frames < 65535) begin
            m_win_frames++;
         end
      end
   endtask

   task automatic compare_all(input string ph);
      check_val({ph, ".screen_sel"}, int'(screen_sel), m_shown);
      check_val({ph, ".game_enable"}, int'(game_enable), int'(m_screen == SCR_GAME));
      check_val({ph, ".game_restart"}, int'(game_restart), int'(m_restart));
      check_val({ph, ".blink_on"}, int'(blink_on), int'(m_blink));
   endtask

   // Finish a cycle: let the edge happen, advance the model, compare.
   task automatic settle(input string ph);
      @(posedge clk);
      #1;
      model_step(frame_tick, start_btn, p1_win, p2_win);
      compare_all(ph);
   endtask

   task automatic apply(input string ph, input bit t, input bit b, input bit w1, input bit w2);
      @(negedge clk);
      frame_tick = t;
      start_btn  = b;
      p1_win     = w1;
      p2_win     = w2;
      settle(ph);
   endtask

   task automatic check_reset_values(input string ph);
      check_val({ph, ".screen_sel"}, int'(screen_sel), 0);
      check_val({ph, ".game_enable"}, int'(game_enable), 0);
      check_val({ph, ".game_restart"}, int'(game_restart), 0);
      check_val({ph, ".blink_on"}, int'(blink_on), 0);
   endtask

   // Called just after a compare (edge + 1): reset asserts between edges,
   // so outputs must clear before any clock edge arrives.
   task automatic do_async_reset(input string ph, input bit btn_after);
      #2;
      reset = 1'b1;
      #1;
      check_reset_values({ph, ".async"});
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset      = 1'b0;
      frame_tick = 1'b0;
      p1_win     = 1'b0;
      p2_win     = 1'b0;
      start_btn  = btn_after;
      settle({ph, ".release"});
   endtask

   initial begin
      bit r_btn;
      model_reset();

      // Reset with start held high, then a held button must not start.
      #1 reset = 1'b1;
      #1 check_reset_values("por");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      settle("por_release");
      repeat (3) apply("held", 1'b0, 1'b1, 1'b0, 1'b0);
      apply("held_tick", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("no_restart_when_held", int'(game_restart), 0);
      apply("released", 1'b0, 1'b0, 1'b0, 1'b0);
      apply("press", 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("restart_on_press", int'(game_restart), 1);
      check_val("sel_waits_for_tick", int'(screen_sel), SCR_TITLE);
      apply("after_press", 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("restart_single_cycle", int'(game_restart), 0);
      apply("play_tick", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("sel_game", int'(screen_sel), SCR_GAME);

      // Simultaneous wins resolve to player 1.
      apply("both_win", 1'b0, 1'b1, 1'b1, 1'b1);
      check_val("enable_drops", int'(game_enable), 0);
      apply("win1_tick1", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("sel_p1", int'(screen_sel), SCR_P1);

      // Early skip is ignored, later skip returns to title without restart.
      apply("w1_rel", 1'b0, 1'b0, 1'b0, 1'b0);
      apply("w1_early_press", 1'b0, 1'b1, 1'b0, 1'b0);
      apply("win1_tick2", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("early_skip_ignored", int'(screen_sel), SCR_P1);
      apply("w1_rel2", 1'b0, 1'b0, 1'b0, 1'b0);
      apply("w1_skip", 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("skip_no_restart", int'(game_restart), 0);
      apply("title_tick", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("sel_title_after_skip", int'(screen_sel), SCR_TITLE);

      // Blink in title, then entering play forces it off.
      for (int k = 0; k < 7; k++) begin
         apply("blink_tick", 1'b1, 1'b0, 1'b0, 1'b0);
         apply("blink_idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
      apply("blink_press", 1'b0, 1'b1, 1'b0, 1'b0);
      check_val("blink_off_in_play", int'(blink_on), 0);

      // Player 2 wins, then auto-return after WIN_F frames.
      apply("p2", 1'b0, 1'b1, 1'b0, 1'b1);
      for (int k = 0; k < WIN_F; k++) begin
         apply("win2_tick", 1'b1, 1'b1, 1'b0, 1'b0);
         apply("win2_idle", 1'b0, 1'b1, 1'b0, 1'b0);
      end
      apply("win2_back_tick", 1'b1, 1'b1, 1'b0, 1'b0);
      check_val("auto_return_title", int'(screen_sel), SCR_TITLE);

      // Reset in the middle of the restart pulse.
      apply("rp_rel", 1'b0, 1'b0, 1'b0, 1'b0);
      apply("rp_press", 1'b0, 1'b1, 1'b0, 1'b0);
      do_async_reset("mid_restart", 1'b1);

      // Reset mid-count in WIN2, then a full win hold must follow.
      apply("mc_rel", 1'b0, 1'b0, 1'b0, 1'b0);
      apply("mc_press", 1'b0, 1'b1, 1'b0, 1'b0);
      apply("mc_p2", 1'b0, 1'b1, 1'b0, 1'b1);
      apply("mc_tick", 1'b1, 1'b1, 1'b0, 1'b0);
      apply("mc_tick", 1'b1, 1'b1, 1'b0, 1'b0);
      do_async_reset("mid_win2", 1'b1);
      apply("mc2_rel", 1'b0, 1'b0, 1'b0, 1'b0);
      apply("mc2_press", 1'b0, 1'b1, 1'b0, 1'b0);
      apply("mc2_p1", 1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < WIN_F + 2; k++) begin
         apply("mc2_tick", 1'b1, 1'b1, 1'b0, 1'b0);
      end

      // Random stimulus against the model.
      r_btn = start_btn;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7) == 0) r_btn = !r_btn;
         apply("rand", $urandom_range(4) == 0, r_btn,
               $urandom_range(15) == 0, $urandom_range(15) == 0);
         if (i % 1000 == 999) begin
            if ($urandom_range(1) == 0) r_btn = !r_btn;
            do_async_reset("rand_reset", r_btn);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
